// File: rtl/button_encoder_if.sv
// Stack-side request/status bundle between the button encoder and the direction stack.
// The encoder side drives the one-cycle requests; the stack side drives its fill flags.
interface button_encoder_if;
  // PUSH, POP and REJECT are single-cycle pulses and never overlap.
  // DATA_OUT is valid whenever PUSH is high and keeps that value until the next PUSH.
  // FULL and EMPTY are level flags; the encoder only looks at them on the cycle it accepts a press.
  logic       PUSH;
  logic       POP;
  logic       REJECT;
  logic [1:0] DATA_OUT;
  logic       FULL;
  logic       EMPTY;

  modport master (output PUSH, output POP, output REJECT, output DATA_OUT,
                  input FULL, input EMPTY);
  modport slave  (input PUSH, input POP, input REJECT, input DATA_OUT,
                  output FULL, output EMPTY);
endinterface

// File: rtl/button_encoder.sv
// Synchronises and debounces four direction buttons plus undo.
// Each accepted press becomes one PUSH, POP or REJECT pulse toward the direction stack.
module button_encoder #(
  parameter int  DEBOUNCE_CYCLES = 50000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [3:0]       BTN,
  input  logic             BTN_UNDO,
  button_encoder_if.master stk,
  output logic [1:0]       STATE_DBG
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  logic [4:0]       sync1;
  logic [4:0]       pat;
  logic [4:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic             push_q;
  logic             pop_q;
  logic             rej_q;
  logic [1:0]       data_q;

  function automatic logic [1:0] dir_index(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1  <= '0;
      pat    <= '0;
      cand   <= '0;
      cnt    <= '0;
      state  <= IDLE;
      push_q <= 1'b0;
      pop_q  <= 1'b0;
      rej_q  <= 1'b0;
      data_q <= 2'd0;
    end else begin
      sync1  <= {BTN_UNDO, BTN};
      pat    <= sync1;
      push_q <= 1'b0;
      pop_q  <= 1'b0;
      rej_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (pat != 5'd0) begin
            state <= SETTLE;
            cand  <= pat;
            cnt   <= '0;
          end
        end
        SETTLE: begin
          if (pat == 5'd0) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (pat != cand) begin
            cand <= pat;
            cnt  <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= HELD;
            cnt   <= '0;
            // Stack flags are consulted here only, so a request is never issued that would be dropped.
            if (!cand[4] && $onehot(cand[3:0])) begin
              if (!stk.FULL) begin
                push_q <= 1'b1;
                data_q <= dir_index(cand[3:0]);
              end else begin
                rej_q <= 1'b1;
              end
            end else if (cand == 5'b10000) begin
              if (!stk.EMPTY) pop_q <= 1'b1;
              else            rej_q <= 1'b1;
            end else begin
              rej_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HELD: begin
          if (pat == 5'd0) begin
            state <= RELEASE;
            cnt   <= '0;
          end
        end
        RELEASE: begin
          // Any bounce back to a pressed pattern must wait out a full quiet period again.
          if (pat != 5'd0) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign stk.PUSH     = push_q;
  assign stk.POP      = pop_q;
  assign stk.REJECT   = rej_q;
  assign stk.DATA_OUT = data_q;
  assign STATE_DBG    = state;

endmodule

// File: tb/tb_button_encoder.sv
// Bench for button_encoder with a short debounce window.
// A run-length reference model predicts every output cycle; directed scenarios add timing and count checks.
module tb_button_encoder;
  localparam int D = 4;

  logic       CLK;
  logic       RST_N;
  logic [3:0] BTN;
  logic       BTN_UNDO;
  logic [1:0] STATE_DBG;

  button_encoder_if stk_if ();

  button_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .BTN       (BTN),
    .BTN_UNDO  (BTN_UNDO),
    .stk       (stk_if),
    .STATE_DBG (STATE_DBG)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- scoreboard ----------------
  // Each entry is {push, pop, reject, data_out[1:0]} for one cycle.
  logic [4:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: raw patterns delayed two edges, plus run-length tracking.
  logic [4:0] dly_q[$];
  logic [5:0] run_val;
  int         run_len;
  bit         armed;
  logic [1:0] m_data;

  // Per-window counters of DUT actions for directed checks.
  int n_push, n_pop, n_rej, first_push, step_idx;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // An accepted press is a run of D+1 identical nonzero samples that starts after re-arming;
  // re-arming is a run of D+1 all-zero samples that starts after the last accept.
  task automatic model_edge(input bit rst_n, input logic [4:0] raw, input bit full, input bit empty);
    logic [4:0] s;
    bit p, po, r;
    p = 0; po = 0; r = 0;
    if (!rst_n) begin
      dly_q   = '{5'd0, 5'd0};
      armed   = 1;
      run_val = 6'h20;
      run_len = 0;
      m_data  = 2'd0;
      exp_q.push_back(5'd0);
      return;
    end
    s = dly_q.pop_front();
    dly_q.push_back(raw);
    if ({1'b0, s} == run_val) run_len++;
    else begin
      run_val = {1'b0, s};
      run_len = 1;
    end
    if (run_len >= D + 1) begin
      if (armed && s != 5'd0) begin
        if (s[4] == 1'b0 && $onehot(s[3:0])) begin
          if (!full) begin
            p = 1;
            for (int i = 0; i < 4; i++) if (s[i]) m_data = 2'(i);
          end else r = 1;
        end else if (s == 5'b10000) begin
          if (!empty) po = 1;
          else r = 1;
        end else r = 1;
        armed   = 0;
        run_val = 6'h20;
        run_len = 0;
      end else if (!armed && s == 5'd0) begin
        armed   = 1;
        run_val = 6'h20;
        run_len = 0;
      end
    end
    exp_q.push_back({p, po, r, m_data});
  endtask

  task automatic check_outputs();
    logic [4:0] e;
    if (exp_q.size() == 0) begin
      n_total++;
      $error("FAIL exp_q: observed empty expected entry");
      return;
    end
    e = exp_q.pop_front();
    check_val("push",   8'(stk_if.PUSH),     8'(e[4]));
    check_val("pop",    8'(stk_if.POP),      8'(e[3]));
    check_val("reject", 8'(stk_if.REJECT),   8'(e[2]));
    check_val("data",   8'(stk_if.DATA_OUT), 8'(e[1:0]));
    check_val("excl",   8'($onehot0({stk_if.PUSH, stk_if.POP, stk_if.REJECT})), 8'd1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    model_edge(RST_N, {BTN_UNDO, BTN}, stk_if.FULL, stk_if.EMPTY);
    @(posedge CLK);
    #1;
    check_outputs();
    step_idx++;
    if (stk_if.PUSH) begin
      n_push++;
      if (first_push == 0) first_push = step_idx;
    end
    if (stk_if.POP)    n_pop++;
    if (stk_if.REJECT) n_rej++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_counts();
    n_push = 0; n_pop = 0; n_rej = 0; first_push = 0; step_idx = 0;
  endtask

  task automatic set_btn(input logic [3:0] b, input logic u);
    BTN      = b;
    BTN_UNDO = u;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hold_left;
    int sel;
    logic [4:0] rp;

    RST_N = 1'b0;
    set_btn(4'd0, 1'b0);
    stk_if.FULL  = 1'b0;
    stk_if.EMPTY = 1'b0;
    clear_counts();
    #2;
    run(2);
    check_val("reset_state", 8'(STATE_DBG), 8'd0);
    RST_N = 1'b1;

    // Single press: raw stable at edge N gives PUSH after edge N+2+D, i.e. the 7th step.
    run(9);
    set_btn(4'b0100, 1'b0);
    clear_counts();
    run(14);
    check_val("first_push_step", 8'(first_push), 8'd7);
    check_val("single_push", 8'(n_push), 8'd1);
    set_btn(4'd0, 1'b0);
    run(10);

    // Toggling every 2 cycles must never be accepted, then one PUSH once stable.
    clear_counts();
    for (int i = 0; i < 3; i++) begin
      set_btn(4'b0100, 1'b0); run(2);
      set_btn(4'd0, 1'b0);    run(2);
    end
    check_val("toggle_no_push", 8'(n_push), 8'd0);
    set_btn(4'b0100, 1'b0);
    run(12);
    check_val("toggle_then_push", 8'(n_push), 8'd1);
    set_btn(4'd0, 1'b0);
    run(10);

    // Undo against an empty stack, then against a non-empty one.
    stk_if.EMPTY = 1'b1;
    clear_counts();
    set_btn(4'd0, 1'b1); run(10);
    check_val("undo_empty_rej", 8'(n_rej), 8'd1);
    check_val("undo_empty_pop", 8'(n_pop), 8'd0);
    set_btn(4'd0, 1'b0); run(10);
    stk_if.EMPTY = 1'b0;
    clear_counts();
    set_btn(4'd0, 1'b1); run(10);
    check_val("undo_pop", 8'(n_pop), 8'd1);
    check_val("undo_data_kept", 8'(stk_if.DATA_OUT), 8'd2);
    set_btn(4'd0, 1'b0); run(10);

    // Multiple buttons, then a direction against a full stack.
    clear_counts();
    set_btn(4'b0011, 1'b0); run(10);
    check_val("multi_rej", 8'(n_rej), 8'd1);
    check_val("multi_no_push", 8'(n_push), 8'd0);
    set_btn(4'd0, 1'b0); run(10);
    stk_if.FULL = 1'b1;
    clear_counts();
    set_btn(4'b1000, 1'b0); run(10);
    check_val("full_rej", 8'(n_rej), 8'd1);
    check_val("full_data_kept", 8'(stk_if.DATA_OUT), 8'd2);
    set_btn(4'd0, 1'b0); run(10);
    stk_if.FULL = 1'b0;

    // Short release does not re-arm; a long one does.
    clear_counts();
    set_btn(4'b0010, 1'b0); run(10);
    set_btn(4'd0, 1'b0);    run(2);
    set_btn(4'b0010, 1'b0); run(10);
    check_val("short_release", 8'(n_push), 8'd1);
    set_btn(4'd0, 1'b0);    run(10);
    set_btn(4'b0010, 1'b0); run(10);
    check_val("long_release", 8'(n_push), 8'd2);
    check_val("data_dir1", 8'(stk_if.DATA_OUT), 8'd1);
    set_btn(4'd0, 1'b0); run(10);

    // Reset while settling with the button still held.
    set_btn(4'b0001, 1'b0);
    run(4);
    RST_N = 1'b0;
    run(1);
    check_val("rst_push", 8'(stk_if.PUSH), 8'd0);
    check_val("rst_data", 8'(stk_if.DATA_OUT), 8'd0);
    RST_N = 1'b1;
    clear_counts();
    run(12);
    check_val("rst_first_push", 8'(first_push), 8'd7);
    check_val("rst_one_push", 8'(n_push), 8'd1);
    set_btn(4'd0, 1'b0); run(10);

    // Random phase: bursts of held patterns with random flags and occasional resets.
    hold_left = 0;
    rp = 5'd0;
    for (int c = 0; c < 1500; c++) begin
      if (hold_left == 0) begin
        sel = $urandom_range(0, 9);
        case (sel)
          0, 1, 2: rp = 5'd0;
          3, 4, 5, 6: rp = 5'(1 << $urandom_range(0, 3));
          7: rp = 5'b10000;
          8: rp = 5'($urandom_range(1, 31));
          default: rp = 5'b10000 | 5'(1 << $urandom_range(0, 3));
        endcase
        hold_left = $urandom_range(1, 12);
      end
      hold_left--;
      set_btn(rp[3:0], rp[4]);
      stk_if.FULL  = ($urandom_range(0, 3) == 0);
      stk_if.EMPTY = ($urandom_range(0, 3) == 0);
      RST_N = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
